// File: rtl/counter_bank_pkg.sv
// Shared widths and max-value helpers for the counter bank and its channels.
package counter_bank_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int CNT_W_DEF  = 8;
    localparam int DIV_W_DEF  = 24;

    localparam logic [31:0] CNT_MAX_DEF = 32'h0000_00FF;

    // All-ones value of a w-bit counter, w in 1..32.
    function automatic logic [31:0] max_val(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: prescaler, up/down counter and registered compare flags.
// COUNTER_BANK_SATURATE_EN selects saturation instead of wrap at the boundaries.
module counter_channel
    import counter_bank_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_cmp,
    input  logic             clr,
    input  logic             auto_en,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count,
    output logic             eq_zero,
    output logic             eq_cmp,
    output logic             eq_max,
    output logic             wrap_evt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(max_val(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    logic [CNT_W-1:0] count_r;
    logic             wrap_r;
    logic             eq_zero_r;
    logic             eq_cmp_r;
    logic             eq_max_r;
    logic             inc_s;
    logic             dec_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             wrap_nxt_s;

    // Prescaler: reload from cfg_div when expired, pulsing tick for that cycle.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            div_r  <= DIV_ZERO;
            tick_r <= 1'b0;
        end else if (div_r == DIV_ZERO) begin
            div_r  <= cfg_div;
            tick_r <= 1'b1;
        end else begin
            div_r  <= div_r - DIV_ONE;
            tick_r <= 1'b0;
        end
    end

    // Command priority: clear, then up, then down, then prescaled auto count.
    always_comb begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        if (clr) begin
            inc_s = 1'b0;
            dec_s = 1'b0;
        end else if (up) begin
            inc_s = 1'b1;
        end else if (down) begin
            dec_s = 1'b1;
        end else if (auto_en && tick_r) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
            dec_s = 1'b0;
        end
    end

    // Next count and boundary event; clear never reports a boundary event.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (clr) begin
            count_nxt_s = CNT_ZERO;
        end else if (inc_s) begin
            if (count_r == CNT_MAX) begin
                wrap_nxt_s = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
                count_nxt_s = CNT_MAX;
`else
                count_nxt_s = CNT_ZERO;
`endif
            end else begin
                count_nxt_s = count_r + CNT_ONE;
            end
        end else if (dec_s) begin
            if (count_r == CNT_ZERO) begin
                wrap_nxt_s = 1'b1;
`ifdef COUNTER_BANK_SATURATE_EN
                count_nxt_s = CNT_ZERO;
`else
                count_nxt_s = CNT_MAX;
`endif
            end else begin
                count_nxt_s = count_r - CNT_ONE;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count and its boundary event update together so they appear in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            count_r <= CNT_ZERO;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    // Flags are computed from the registered count, one cycle behind count.
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            eq_zero_r <= 1'b1;
            eq_cmp_r  <= 1'b0;
            eq_max_r  <= 1'b0;
        end else begin
            eq_zero_r <= (count_r == CNT_ZERO);
            eq_cmp_r  <= (count_r == cfg_cmp);
            eq_max_r  <= (count_r == CNT_MAX);
        end
    end

    assign count    = count_r;
    assign wrap_evt = wrap_r;
    assign eq_zero  = eq_zero_r;
    assign eq_cmp   = eq_cmp_r;
    assign eq_max   = eq_max_r;

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent prescaled up/down counters with compare flags.
// COUNTER_BANK_SATURATE_EN (in counter_channel) selects saturating boundaries.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*CNT_W-1:0] cfg_cmp,
    input  logic [NUM_CH-1:0]       ctl_clr,
    input  logic [NUM_CH-1:0]       ctl_auto,
    input  logic [NUM_CH-1:0]       ctl_up,
    input  logic [NUM_CH-1:0]       ctl_down,
    output logic [NUM_CH*CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]       eq_zero,
    output logic [NUM_CH-1:0]       eq_cmp,
    output logic [NUM_CH-1:0]       eq_max,
    output logic [NUM_CH-1:0]       wrap_evt
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .CNT_W (CNT_W),
            .DIV_W (DIV_W)
        ) u_ch (
            .sys_clk  (sys_clk),
            .reset_n  (reset_n),
            .cfg_div  (cfg_div[i*DIV_W +: DIV_W]),
            .cfg_cmp  (cfg_cmp[i*CNT_W +: CNT_W]),
            .clr      (ctl_clr[i]),
            .auto_en  (ctl_auto[i]),
            .up       (ctl_up[i]),
            .down     (ctl_down[i]),
            .count    (count_out[i*CNT_W +: CNT_W]),
            .eq_zero  (eq_zero[i]),
            .eq_cmp   (eq_cmp[i]),
            .eq_max   (eq_max[i]),
            .wrap_evt (wrap_evt[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_counter_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 24;

    localparam int K_CNT  = 0;
    localparam int K_WRAP = 1;
    localparam int K_ZERO = 2;
    localparam int K_CMP  = 3;
    localparam int K_MAX  = 4;

`ifdef COUNTER_BANK_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                    sys_clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_CH*DIV_W-1:0] cfg_div = '0;
    logic [NUM_CH*CNT_W-1:0] cfg_cmp = '0;
    logic [NUM_CH-1:0]       ctl_clr = '0;
    logic [NUM_CH-1:0]       ctl_auto = '0;
    logic [NUM_CH-1:0]       ctl_up = '0;
    logic [NUM_CH-1:0]       ctl_down = '0;
    logic [NUM_CH*CNT_W-1:0] count_out;
    logic [NUM_CH-1:0]       eq_zero;
    logic [NUM_CH-1:0]       eq_cmp;
    logic [NUM_CH-1:0]       eq_max;
    logic [NUM_CH-1:0]       wrap_evt;

    typedef struct {
        int          cyc;
        int          kind;
        int          ch;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .cfg_div   (cfg_div),
        .cfg_cmp   (cfg_cmp),
        .ctl_clr   (ctl_clr),
        .ctl_auto  (ctl_auto),
        .ctl_up    (ctl_up),
        .ctl_down  (ctl_down),
        .count_out (count_out),
        .eq_zero   (eq_zero),
        .eq_cmp    (eq_cmp),
        .eq_max    (eq_max),
        .wrap_evt  (wrap_evt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind, input int ch);
        case (kind)
            K_CNT:   return 32'(count_out[ch*CNT_W +: CNT_W]);
            K_WRAP:  return 32'(wrap_evt[ch]);
            K_ZERO:  return 32'(eq_zero[ch]);
            K_CMP:   return 32'(eq_cmp[ch]);
            K_MAX:   return 32'(eq_max[ch]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int dc, input int kind, input int ch,
                             input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = kind;
        e.ch   = ch;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Monitor: compare every queued expectation that falls due in this cycle.
    always @(negedge sys_clk) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                act = actual(q[i].kind, q[i].ch);
                checks++;
                if (act !== q[i].exp) begin
                    errors++;
                    $display("FAIL %s ch%0d cyc%0d: got 0x%0h expected 0x%0h",
                             q[i].name, q[i].ch, cyc, act, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        cfg_div[0*DIV_W +: DIV_W] = 24'd3;
        cfg_cmp[1*CNT_W +: CNT_W] = 8'h80;
        ctl_auto[0] = 1'b1;
        step();
        step();
        checks++;
        if (count_out !== {(NUM_CH*CNT_W){1'b0}}) begin
            errors++;
            $display("FAIL direct_rst_count: got 0x%0h expected 0x0", count_out);
        end
        checks++;
        if (eq_zero !== {NUM_CH{1'b1}}) begin
            errors++;
            $display("FAIL direct_rst_eq_zero: got 0x%0h expected 0x%0h", eq_zero, {NUM_CH{1'b1}});
        end
        checks++;
        if (wrap_evt !== {NUM_CH{1'b0}}) begin
            errors++;
            $display("FAIL direct_rst_wrap: got 0x%0h expected 0x0", wrap_evt);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            expect_at(0, K_CNT,  c, 32'h0, "rst_count");
            expect_at(0, K_ZERO, c, 32'h1, "rst_eq_zero");
            expect_at(0, K_CMP,  c, 32'h0, "rst_eq_cmp");
            expect_at(0, K_MAX,  c, 32'h0, "rst_eq_max");
            expect_at(0, K_WRAP, c, 32'h0, "rst_wrap");
        end

        // Prescaled auto count, cfg_div=3: first tick right after release.
        reset_n = 1'b1;
        expect_at(2,  K_CNT,  0, 32'd1,  "auto_first");
        expect_at(2,  K_ZERO, 0, 32'd1,  "auto_zero_lag");
        expect_at(3,  K_ZERO, 0, 32'd0,  "auto_zero_fall");
        expect_at(5,  K_CNT,  0, 32'd1,  "auto_hold");
        expect_at(6,  K_CNT,  0, 32'd2,  "auto_second");
        expect_at(40, K_CNT,  0, 32'd10, "auto_40cyc");
        expect_at(40, K_CNT,  1, 32'd0,  "auto_ch1_idle");
        repeat (40) step();
        ctl_auto[0] = 1'b0;
        expect_at(2, K_CNT, 0, 32'd10, "auto_off_hold");

        // Decrement wrap from 0, then clear without an event.
        ctl_down[2] = 1'b1;
        expect_at(1, K_CNT,  2, SAT ? 32'h00 : 32'hFF, "dec_wrap_cnt");
        expect_at(1, K_WRAP, 2, 32'h1, "dec_wrap_evt");
        step();
        ctl_down[2] = 1'b0;
        ctl_clr[2]  = 1'b1;
        expect_at(1, K_CNT,  2, 32'h0, "clr_cnt");
        expect_at(1, K_WRAP, 2, 32'h0, "clr_no_wrap");
        step();
        ctl_clr[2] = 1'b0;

        // Climb to 0xFF, then one more up: wrap (or saturate) with event.
        ctl_up[2] = 1'b1;
        expect_at(255, K_CNT,  2, 32'hFF, "climb_ff");
        expect_at(255, K_WRAP, 2, 32'h0,  "climb_no_wrap");
        expect_at(256, K_MAX,  2, 32'h1,  "eq_max_ff");
        repeat (255) step();
        expect_at(1, K_CNT,  2, SAT ? 32'hFF : 32'h00, "inc_wrap_cnt");
        expect_at(1, K_WRAP, 2, 32'h1, "inc_wrap_evt");
        expect_at(2, K_WRAP, 2, 32'h0, "inc_wrap_one_cycle");
        expect_at(2, K_ZERO, 2, SAT ? 32'h0 : 32'h1, "inc_wrap_eq_zero");
        step();
        ctl_up[2] = 1'b0;
        step();
        step();

        // Up+down together counts up; clear beats up.
        ctl_up[3] = 1'b1;
        expect_at(5, K_CNT, 3, 32'd5, "ch3_five");
        repeat (5) step();
        ctl_down[3] = 1'b1;
        expect_at(1, K_CNT,  3, 32'd6, "updown_is_up");
        expect_at(1, K_WRAP, 3, 32'h0, "updown_no_wrap");
        step();
        ctl_down[3] = 1'b0;
        ctl_clr[3]  = 1'b1;
        expect_at(1, K_CNT,  3, 32'd0, "clr_beats_up");
        expect_at(1, K_WRAP, 3, 32'h0, "clr_up_no_wrap");
        step();
        ctl_clr[3] = 1'b0;
        ctl_up[3]  = 1'b0;
        step();

        // Compare flag at 0x80 lags count_out by one cycle.
        ctl_up[1] = 1'b1;
        expect_at(126, K_CNT, 1, 32'h7E, "ch1_7e");
        repeat (126) step();
        ctl_up[1]   = 1'b0;
        ctl_auto[1] = 1'b1;
        expect_at(1, K_CNT, 1, 32'h7F, "cmp_7f");
        expect_at(2, K_CNT, 1, 32'h80, "cmp_80");
        expect_at(2, K_CMP, 1, 32'h0,  "cmp_not_yet");
        expect_at(3, K_CMP, 1, 32'h1,  "cmp_rise");
        expect_at(4, K_CMP, 1, 32'h0,  "cmp_fall");
        expect_at(3, K_CNT, 0, 32'd10, "ch0_untouched");
        repeat (3) step();
        ctl_auto[1] = 1'b0;
        step();
        step();

        // Reset mid-count at 0x42 overrides active controls on every channel.
        ctl_clr[1] = 1'b1;
        step();
        ctl_clr[1] = 1'b0;
        ctl_up[1]  = 1'b1;
        expect_at(66, K_CNT, 1, 32'h42, "ch1_42");
        expect_at(66, K_CNT, 0, 32'd10, "ch0_before_rst");
        repeat (66) step();
        ctl_up[1] = 1'b0;
        ctl_up[3] = 1'b1;
        reset_n   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            expect_at(1, K_CNT,  c, 32'h0, "mid_rst_count");
            expect_at(1, K_ZERO, c, 32'h1, "mid_rst_eq_zero");
            expect_at(1, K_WRAP, c, 32'h0, "mid_rst_wrap");
        end
        step();
        checks++;
        if (count_out !== {(NUM_CH*CNT_W){1'b0}}) begin
            errors++;
            $display("FAIL direct_mid_rst_count: got 0x%0h expected 0x0", count_out);
        end
        checks++;
        if (eq_zero !== {NUM_CH{1'b1}}) begin
            errors++;
            $display("FAIL direct_mid_rst_eq_zero: got 0x%0h expected 0x%0h", eq_zero, {NUM_CH{1'b1}});
        end
        reset_n   = 1'b1;
        ctl_up[3] = 1'b0;
        expect_at(2, K_CNT,  0, 32'h0, "post_rst_count");
        expect_at(2, K_ZERO, 0, 32'h1, "post_rst_eq_zero");
        step();
        step();

        repeat (4) step();
        while (q.size() > 0) begin
            errors++;
            $display("FAIL %s ch%0d: expectation for cyc%0d never compared (got none, required 0x%0h)",
                     q[0].name, q[0].ch, q[0].cyc, q[0].exp);
            void'(q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
